// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: word-level wrapper around a one-bit serial adder stage.
// Accepts an operand pair, streams it LSB-first into the external adder while
// its carry flop is released, gathers the returned sum bits and offers the
// N-bit result on an output valid/ready handshake.
module serial_add_sequencer #(
  parameter  int N  = 32,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         ser_a,
  output logic         ser_b,
  output logic         ser_carry_clr,
  input  logic         ser_c,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         r_state;
  logic [N-1:0]   r_sh_a;
  logic [N-1:0]   r_sh_b;
  logic [N-1:0]   r_res;
  logic [CW-1:0]  r_cnt;
  logic           r_out_valid;

  logic [N-1:0]   w_res_next;
  logic           w_in_idle;
  logic           w_shifting;
  logic           w_last_bit;

  // Reset forces the handshake closed and the adder carry held clear.
  assign w_in_idle  = rst && (r_state == IDLE);
  assign w_shifting = rst && (r_state == SHIFT);
  assign w_last_bit = (r_cnt == CW'(N - 1));

  // Incoming sum bit enters at the MSB so that after N shifts bit 0 lands in res[0].
  generate
    if (N == 1) begin : g_res_one
      assign w_res_next = ser_c;
    end else begin : g_res_wide
      assign w_res_next = {ser_c, r_res[N-1:1]};
    end
  endgenerate

  // Output drive derived from the state register; carry is cleared in every non-SHIFT cycle.
  assign in_ready      = w_in_idle;
  assign ser_a         = w_shifting & r_sh_a[0];
  assign ser_b         = w_shifting & r_sh_b[0];
  assign ser_carry_clr = ~w_shifting;
  assign out_valid     = r_out_valid;
  assign out_sum       = r_res;

  // Sequencer FSM: accept operands, shift N bits through the adder, hold result until taken.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_sh_a      <= '0;
      r_sh_b      <= '0;
      r_res       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sh_a  <= in_a;
            r_sh_b  <= in_b;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_res  <= w_res_next;
          r_sh_a <= r_sh_a >> 1;
          r_sh_b <= r_sh_b >> 1;
          if (w_last_bit) begin
            r_cnt       <= '0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb_serial_add_sequencer: checks an N=8 and an N=1 sequencer, each wired to a
// behavioural one-bit adder with a clearable carry flop.
module tb_serial_add_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- N=8 instance ----------------
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_a, in_b, out_sum;
  logic       ser_a, ser_b, ser_c, ser_carry_clr;
  logic       carry8;

  serial_add_sequencer #(.N(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .ser_a(ser_a), .ser_b(ser_b), .ser_carry_clr(ser_carry_clr), .ser_c(ser_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
  );

  // Serial adder stage: combinational sum, carry flop cleared by ser_carry_clr.
  assign ser_c = ser_a ^ ser_b ^ carry8;
  always @(posedge clk) begin
    if (ser_carry_clr) carry8 <= 1'b0;
    else               carry8 <= (ser_a & ser_b) | (ser_a & carry8) | (ser_b & carry8);
  end

  // ---------------- N=1 instance ----------------
  logic       n1_in_valid, n1_in_ready, n1_out_valid, n1_out_ready;
  logic [0:0] n1_in_a, n1_in_b, n1_out_sum;
  logic       n1_ser_a, n1_ser_b, n1_ser_c, n1_clr;
  logic       carry1;

  serial_add_sequencer #(.N(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(n1_in_valid), .in_ready(n1_in_ready), .in_a(n1_in_a), .in_b(n1_in_b),
    .ser_a(n1_ser_a), .ser_b(n1_ser_b), .ser_carry_clr(n1_clr), .ser_c(n1_ser_c),
    .out_valid(n1_out_valid), .out_ready(n1_out_ready), .out_sum(n1_out_sum)
  );

  assign n1_ser_c = n1_ser_a ^ n1_ser_b ^ carry1;
  always @(posedge clk) begin
    if (n1_clr) carry1 <= 1'b0;
    else        carry1 <= (n1_ser_a & n1_ser_b) | (n1_ser_a & carry1) | (n1_ser_b & carry1);
  end

  // ---------------- checking helpers ----------------
  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the word result is plain modular addition.
  function automatic logic [7:0] ref_sum(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] full;
    full = {1'b0, a} + {1'b0, b};
    return full[7:0];
  endfunction

  // Present operands in an IDLE cycle; returns after the accepting edge.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    int k;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk1("idle_in_ready", in_ready, 1'b1);
    chk1("idle_carry_clr", ser_carry_clr, 1'b1);
    chk1("idle_ser_a", ser_a, 1'b0);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Cycles t+1..t+8 stream bits LSB-first; cycle t+9 shows the result.
  task automatic shift_and_result(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] exp;
    exp = ref_sum(a, b);
    for (int i = 0; i < 8; i++) begin
      chk1("shift_ser_a", ser_a, a[i]);
      chk1("shift_ser_b", ser_b, b[i]);
      chk1("shift_carry_clr", ser_carry_clr, 1'b0);
      chk1("shift_in_ready", in_ready, 1'b0);
      chk1("shift_out_valid", out_valid, 1'b0);
      @(negedge clk);
    end
    chk1("done_out_valid", out_valid, 1'b1);
    chk8("done_out_sum", out_sum, exp);
    chk1("done_carry_clr", ser_carry_clr, 1'b1);
    chk1("done_in_ready", in_ready, 1'b0);
    $display("op 0x%02h + 0x%02h -> out_sum 0x%02h (expected 0x%02h)", a, b, out_sum, exp);
  endtask

  task automatic consume(input int delay);
    repeat (delay) begin
      @(negedge clk);
      chk1("hold_out_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk1("after_take_out_valid", out_valid, 1'b0);
    chk1("after_take_in_ready", in_ready, 1'b1);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] held;
    logic [7:0] ra, rb;

    tbl[0] = '{a: 8'h5A, b: 8'h3C, sum: 8'h96};
    tbl[1] = '{a: 8'hFF, b: 8'h01, sum: 8'h00};
    tbl[2] = '{a: 8'hFF, b: 8'hFF, sum: 8'hFE};
    tbl[3] = '{a: 8'h00, b: 8'h00, sum: 8'h00};
    tbl[4] = '{a: 8'h80, b: 8'h80, sum: 8'h00};
    tbl[5] = '{a: 8'h12, b: 8'h34, sum: 8'h46};

    rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    n1_in_valid = 1'b0; n1_in_a = '0; n1_in_b = '0; n1_out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_carry_clr", ser_carry_clr, 1'b1);
    chk1("rst_ser_a", ser_a, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk8("rst_out_sum", out_sum, 8'h00);
    chk1("rst_n1_in_ready", n1_in_ready, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk1("post_rst_in_ready", in_ready, 1'b1);

    // Table vectors, back-to-back (0xFF+0xFF then 0x00+0x00 is consecutive)
    for (int i = 0; i < 6; i++) begin
      start_op(tbl[i].a, tbl[i].b);
      shift_and_result(tbl[i].a, tbl[i].b);
      chk8("table_sum", out_sum, tbl[i].sum);
      consume(0);
    end

    // Backpressure with new operands waiting
    start_op(8'hA5, 8'h0F);
    shift_and_result(8'hA5, 8'h0F);
    held = out_sum;
    in_valid = 1'b1; in_a = 8'h21; in_b = 8'h43;
    repeat (5) begin
      @(negedge clk);
      chk1("bp_out_valid", out_valid, 1'b1);
      chk8("bp_out_sum_stable", out_sum, held);
      chk1("bp_in_ready", in_ready, 1'b0);
      chk1("bp_carry_clr", ser_carry_clr, 1'b1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk1("bp_idle_out_valid", out_valid, 1'b0);
    chk1("bp_idle_in_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    shift_and_result(8'h21, 8'h43);
    consume(0);

    // Reset on the 4th SHIFT cycle of 0x12+0x34
    start_op(8'h12, 8'h34);
    repeat (3) @(negedge clk);
    chk1("mid_shift_carry_clr", ser_carry_clr, 1'b0);
    rst = 1'b0;
    #1;
    chk1("rst_forced_in_ready", in_ready, 1'b0);
    chk1("rst_forced_carry_clr", ser_carry_clr, 1'b1);
    chk1("rst_forced_ser_a", ser_a, 1'b0);
    chk1("rst_forced_ser_b", ser_b, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk8("midrst_res", out_sum, 8'h00);
    #1;
    chk1("midrst_idle_in_ready", in_ready, 1'b1);
    chk1("midrst_idle_carry_clr", ser_carry_clr, 1'b1);
    @(negedge clk);
    start_op(8'h01, 8'h02);
    shift_and_result(8'h01, 8'h02);
    chk8("midrst_followup", out_sum, 8'h03);
    consume(0);

    // Randomized operands with random result backpressure
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      start_op(ra, rb);
      shift_and_result(ra, rb);
      consume(int'($urandom_range(0, 3)));
    end

    // N=1 build: 1+1 -> 0, then 1+0 -> 1
    chk1("n1_idle_ready", n1_in_ready, 1'b1);
    n1_in_valid = 1'b1; n1_in_a = 1'b1; n1_in_b = 1'b1;
    @(negedge clk);
    n1_in_valid = 1'b0;
    chk1("n1_shift_ser_a", n1_ser_a, 1'b1);
    chk1("n1_shift_ser_b", n1_ser_b, 1'b1);
    chk1("n1_shift_clr", n1_clr, 1'b0);
    @(negedge clk);
    chk1("n1_done_valid", n1_out_valid, 1'b1);
    chk1("n1_sum_1p1", n1_out_sum[0], 1'b0);
    chk1("n1_done_clr", n1_clr, 1'b1);
    $display("op N=1 1 + 1 -> out_sum %b (expected 0)", n1_out_sum[0]);
    n1_out_ready = 1'b1;
    @(negedge clk);
    n1_out_ready = 1'b0;
    chk1("n1_taken_valid", n1_out_valid, 1'b0);
    n1_in_valid = 1'b1; n1_in_a = 1'b1; n1_in_b = 1'b0;
    @(negedge clk);
    n1_in_valid = 1'b0;
    chk1("n1_shift2_ser_a", n1_ser_a, 1'b1);
    chk1("n1_shift2_ser_b", n1_ser_b, 1'b0);
    @(negedge clk);
    chk1("n1_done2_valid", n1_out_valid, 1'b1);
    chk1("n1_sum_1p0", n1_out_sum[0], 1'b1);
    $display("op N=1 1 + 0 -> out_sum %b (expected 1)", n1_out_sum[0]);
    n1_out_ready = 1'b1;
    @(negedge clk);
    n1_out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
